// File: rtl/tri_delay_channel_model.sv
// Clocked model of rise/fall/turn-off delays for NCH independent tristate channels.
// Inertial filtering cancels a pending transition when the target returns to the current level.
module tri_delay_channel_model #(
    parameter int NCH = 4,
    parameter int DW  = 4,
    parameter int CW  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] d,
    input  logic [NCH-1:0] oe,
    input  logic [DW-1:0]  rise_dly,
    input  logic [DW-1:0]  fall_dly,
    input  logic [DW-1:0]  off_dly,
    input  logic           glitch_clr,
    output logic [NCH-1:0] out_val,
    output logic [NCH-1:0] out_en,
    output logic [NCH-1:0] busy,
    output logic [CW-1:0]  glitch_cnt
);

    typedef enum logic {STABLE, PEND} state_e;

    // Levels are {driven, value}; Z keeps value 0 so out_val needs no extra masking.
    localparam logic [1:0] LVL_Z = 2'b00;
    localparam logic [1:0] LVL_0 = 2'b10;
    localparam logic [1:0] LVL_1 = 2'b11;
    localparam int NW = $clog2(NCH + 1);
    localparam int SW = CW + NW;

    state_e         state_q [NCH];
    state_e         state_d [NCH];
    logic [1:0]     cur_q   [NCH];
    logic [1:0]     cur_d   [NCH];
    logic [1:0]     pend_q  [NCH];
    logic [1:0]     pend_d  [NCH];
    logic [DW-1:0]  cnt_q   [NCH];
    logic [DW-1:0]  cnt_d   [NCH];
    logic [1:0]     tgt     [NCH];
    logic [DW-1:0]  dly     [NCH];
    logic [NCH-1:0] load;
    logic [NW-1:0]  n_cancel;
    logic [SW-1:0]  glitch_sum;
    logic [CW-1:0]  glitch_cnt_q;
    logic [CW-1:0]  glitch_cnt_d;

    function automatic logic [DW-1:0] sel_dly(input logic [1:0] t, input logic [DW-1:0] r,
                                              input logic [DW-1:0] f, input logic [DW-1:0] o);
        logic [DW-1:0] v;
        case (t)
            LVL_1:   v = r;
            LVL_0:   v = f;
            default: v = o;
        endcase
        return (v == '0) ? DW'(1) : v;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        n_cancel = '0;
        load     = '0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cur_d[i]   = cur_q[i];
            pend_d[i]  = pend_q[i];
            cnt_d[i]   = cnt_q[i];
            tgt[i]     = oe[i] ? (d[i] ? LVL_1 : LVL_0) : LVL_Z;
            dly[i]     = sel_dly(tgt[i], rise_dly, fall_dly, off_dly);

            if (state_q[i] == STABLE) begin
                load[i] = (tgt[i] != cur_q[i]);
            end else if (tgt[i] == pend_q[i]) begin
                if (cnt_q[i] == DW'(1)) begin
                    cur_d[i]   = pend_q[i];
                    state_d[i] = STABLE;
                end else begin
                    cnt_d[i] = cnt_q[i] - DW'(1);
                end
            end else if (tgt[i] == cur_q[i]) begin
                state_d[i] = STABLE;
                n_cancel   = n_cancel + NW'(1);
            end else begin
                load[i] = 1'b1;
            end

            // A restart from PEND follows exactly the same rule as a fresh load from STABLE.
            if (load[i]) begin
                if (dly[i] == DW'(1)) begin
                    cur_d[i]   = tgt[i];
                    state_d[i] = STABLE;
                end else begin
                    pend_d[i]  = tgt[i];
                    cnt_d[i]   = dly[i] - DW'(1);
                    state_d[i] = PEND;
                end
            end
        end

        glitch_sum = SW'(glitch_cnt_q) + SW'(n_cancel);
        if (glitch_clr)
            glitch_cnt_d = '0;
        else if (glitch_sum > SW'({CW{1'b1}}))
            glitch_cnt_d = '1;
        else
            glitch_cnt_d = glitch_sum[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= STABLE;
                cur_q[i]   <= LVL_Z;
                pend_q[i]  <= LVL_Z;
                cnt_q[i]   <= '0;
            end
            glitch_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cur_q[i]   <= cur_d[i];
                pend_q[i]  <= pend_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            out_en[i]  = cur_q[i][1];
            out_val[i] = cur_q[i][0];
            busy[i]    = (state_q[i] == PEND);
        end
        glitch_cnt = glitch_cnt_q;
    end

endmodule

// File: tb/tb_tri_delay_channel_model.sv
// Self-checking bench: hand-derived vector table, directed corner cases and random traffic
// checked against an absolute-time event model of the delayed tristate channels.
module tb_tri_delay_channel_model;

    localparam int NCH = 4;
    localparam int DW  = 4;
    localparam int CW  = 8;
    localparam int GMAX = (1 << CW) - 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] d = '0;
    logic [NCH-1:0] oe = '0;
    logic [DW-1:0]  rise_dly = '0;
    logic [DW-1:0]  fall_dly = '0;
    logic [DW-1:0]  off_dly = '0;
    logic           glitch_clr = 1'b0;
    logic [NCH-1:0] out_val;
    logic [NCH-1:0] out_en;
    logic [NCH-1:0] busy;
    logic [CW-1:0]  glitch_cnt;

    tri_delay_channel_model #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .oe(oe),
        .rise_dly(rise_dly), .fall_dly(fall_dly), .off_dly(off_dly),
        .glitch_clr(glitch_clr), .out_val(out_val), .out_en(out_en),
        .busy(busy), .glitch_cnt(glitch_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Levels in the model: 0, 1, or 2 meaning Z. Transitions are scheduled at absolute edges.
    int m_cur [NCH];
    int m_pend[NCH];
    int m_due [NCH];
    bit m_busy[NCH];
    int m_glitch;
    int cyc;

    function automatic int lvl_of(int i);
        return oe[i] ? int'(d[i]) : 2;
    endfunction

    function automatic int dly_of(int t);
        int v;
        v = (t == 1) ? int'(rise_dly) : (t == 0) ? int'(fall_dly) : int'(off_dly);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cur[i] = 2; m_pend[i] = 2; m_due[i] = 0; m_busy[i] = 0;
        end
        m_glitch = 0;
        cyc = 0;
    endfunction

    function automatic void m_schedule(int i, int t);
        int dl;
        dl = dly_of(t);
        if (dl == 1) begin
            m_cur[i] = t; m_busy[i] = 0;
        end else begin
            m_pend[i] = t; m_due[i] = cyc + dl - 1; m_busy[i] = 1;
        end
    endfunction

    function automatic void m_edge();
        int t, nc;
        cyc++;
        nc = 0;
        for (int i = 0; i < NCH; i++) begin
            t = lvl_of(i);
            if (m_busy[i]) begin
                if (t == m_pend[i]) begin
                    if (cyc == m_due[i]) begin
                        m_cur[i] = m_pend[i]; m_busy[i] = 0;
                    end
                end else if (t == m_cur[i]) begin
                    m_busy[i] = 0; nc++;
                end else begin
                    m_schedule(i, t);
                end
            end else if (t != m_cur[i]) begin
                m_schedule(i, t);
            end
        end
        m_glitch = glitch_clr ? 0 : ((m_glitch + nc > GMAX) ? GMAX : m_glitch + nc);
    endfunction

    function automatic logic [NCH-1:0] exp_en();
        for (int i = 0; i < NCH; i++) exp_en[i] = (m_cur[i] != 2);
    endfunction
    function automatic logic [NCH-1:0] exp_val();
        for (int i = 0; i < NCH; i++) exp_val[i] = (m_cur[i] == 1);
    endfunction
    function automatic logic [NCH-1:0] exp_busy();
        for (int i = 0; i < NCH; i++) exp_busy[i] = m_busy[i];
    endfunction

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic step_chk(input string tag);
        step();
        check({tag, ".out_en"}, 32'(out_en), 32'(exp_en()));
        check({tag, ".out_val"}, 32'(out_val), 32'(exp_val()));
        check({tag, ".busy"}, 32'(busy), 32'(exp_busy()));
        check({tag, ".glitch"}, 32'(glitch_cnt), 32'(m_glitch));
    endtask

    typedef struct {
        logic [NCH-1:0] d, oe;
        logic [DW-1:0]  rise, fall, off;
        logic [NCH-1:0] e_val, e_en, e_busy;
        int             e_glitch;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Channel 0 only; other channels stay Z. Expected values derived by hand from the rules.
        vecs[0]  = '{4'b0001, 4'b0001, 2, 3, 4, 4'b0000, 4'b0000, 4'b0001, 0}; // Z->1 pending
        vecs[1]  = '{4'b0001, 4'b0001, 2, 3, 4, 4'b0001, 4'b0001, 4'b0000, 0}; // lands at k+1
        vecs[2]  = '{4'b0000, 4'b0001, 2, 3, 4, 4'b0001, 4'b0001, 4'b0001, 0}; // 1->0, fall=3
        vecs[3]  = '{4'b0000, 4'b0001, 2, 3, 4, 4'b0001, 4'b0001, 4'b0001, 0};
        vecs[4]  = '{4'b0000, 4'b0001, 2, 3, 4, 4'b0000, 4'b0001, 4'b0000, 0}; // lands at k+2
        vecs[5]  = '{4'b0001, 4'b0001, 0, 3, 4, 4'b0001, 4'b0001, 4'b0000, 0}; // rise=0 -> immediate
        vecs[6]  = '{4'b0000, 4'b0001, 3, 3, 4, 4'b0001, 4'b0001, 4'b0001, 0};
        vecs[7]  = '{4'b0001, 4'b0001, 3, 3, 4, 4'b0001, 4'b0001, 4'b0000, 1}; // cancelled
        vecs[8]  = '{4'b0001, 4'b0000, 3, 3, 4, 4'b0001, 4'b0001, 4'b0001, 1}; // 1->Z, off=4
        vecs[9]  = '{4'b0001, 4'b0000, 3, 3, 4, 4'b0001, 4'b0001, 4'b0001, 1};
        vecs[10] = '{4'b0001, 4'b0000, 3, 3, 4, 4'b0001, 4'b0001, 4'b0001, 1};
        vecs[11] = '{4'b0001, 4'b0000, 3, 3, 4, 4'b0000, 4'b0000, 4'b0000, 1}; // Z at k+3

        m_reset();

        // Reset held: outputs stay at reset values whatever d/oe do.
        for (int i = 0; i < 4; i++) begin
            d = 4'($urandom); oe = 4'($urandom); rise_dly = 1; fall_dly = 1; off_dly = 1;
            @(posedge clk); #1;
            check("rst_hold", {out_en, out_val, busy, glitch_cnt}, '0);
        end
        d = '0; oe = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 12; v++) begin
            d = vecs[v].d; oe = vecs[v].oe;
            rise_dly = vecs[v].rise; fall_dly = vecs[v].fall; off_dly = vecs[v].off;
            step();
            check($sformatf("vec%0d.out_val", v), 32'(out_val), 32'(vecs[v].e_val));
            check($sformatf("vec%0d.out_en", v), 32'(out_en), 32'(vecs[v].e_en));
            check($sformatf("vec%0d.busy", v), 32'(busy), 32'(vecs[v].e_busy));
            check($sformatf("vec%0d.glitch", v), 32'(glitch_cnt), 32'(vecs[v].e_glitch));
        end

        // Single-cycle pulses are filtered; four simultaneous cancels count in one edge.
        oe = 4'b1111; d = '0; rise_dly = 3; fall_dly = 1; off_dly = 4; glitch_clr = 1'b1;
        step_chk("settle0");
        glitch_clr = 1'b0;
        step_chk("settle1");
        d = 4'b0010; step_chk("pulse1_hi");
        d = 4'b0000; step_chk("pulse1_lo");
        check("pulse1_val", 32'(out_val[1]), 32'd0);
        check("pulse1_cnt", 32'(glitch_cnt), 32'd1);
        d = 4'b1111; step_chk("pulse4_hi");
        d = 4'b0000; step_chk("pulse4_lo");
        check("pulse4_cnt", 32'(glitch_cnt), 32'd5);

        // ch2 to 1, then turn off with off=4; then a restart towards 0 mid-turn-off.
        rise_dly = 1; d = 4'b0100; step_chk("ch2_up");
        off_dly = 4; fall_dly = 3; oe = 4'b1011;
        step_chk("off_k");
        step_chk("off_k1");
        step_chk("off_k2");
        check("off_k2_en", 32'(out_en[2]), 32'd1);
        step_chk("off_k3");
        check("off_k3_en", 32'(out_en[2]), 32'd0);
        check("off_k3_val", 32'(out_val[2]), 32'd0);
        oe = 4'b1111; step_chk("ch2_up2");
        step_chk("ch2_up3");
        check("ch2_up3_val", 32'(out_val[2]), 32'd1);
        oe = 4'b1011; step_chk("roff_k");
        step_chk("roff_k1");
        oe = 4'b1111; d = 4'b0000; step_chk("restart_k");
        check("restart_busy", 32'(busy[2]), 32'd1);
        step_chk("restart_k1");
        check("restart_k1_en", 32'(out_en[2]), 32'd1);
        check("restart_k1_val", 32'(out_val[2]), 32'd1);
        step_chk("restart_k2");
        check("restart_k2_val", 32'(out_val[2]), 32'd0);
        check("restart_k2_en", 32'(out_en[2]), 32'd1);
        check("restart_glitch", 32'(glitch_cnt), 32'd5);

        // Saturation: 75 four-channel pulses give 300 more cancels.
        rise_dly = 2; fall_dly = 1;
        for (int n = 0; n < 75; n++) begin
            d = 4'b1111; step();
            d = 4'b0000; step();
        end
        check("sat_cnt", 32'(glitch_cnt), 32'(GMAX));
        check("sat_model", 32'(glitch_cnt), 32'(m_glitch));
        d = 4'b1111; step_chk("clr_hi");
        d = 4'b0000; glitch_clr = 1'b1; step_chk("clr_lo");
        check("clr_wins", 32'(glitch_cnt), 32'd0);
        glitch_clr = 1'b0;

        // Async reset while busy takes effect without a clock edge.
        rise_dly = 5; d = 4'b1111; step_chk("pre_rst");
        check("pre_rst_busy", 32'(busy), 32'hF);
        rst_n = 1'b0; #1;
        m_reset();
        check("async_en", 32'(out_en), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_val", 32'(out_val), 32'd0);
        #1 rst_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            d = 4'($urandom); oe = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d = d ^ 4'($urandom); oe = oe | 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                rise_dly = 4'($urandom_range(0, 5));
                fall_dly = 4'($urandom_range(0, 5));
                off_dly  = 4'($urandom_range(0, 5));
            end
            glitch_clr = ($urandom_range(0, 49) == 0);
            step_chk("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
